retire_unit: RTL
================

# retire_unit

Parametrised in-order commit stage sitting between the reorder buffer head and the architectural register file and data memory. Each cycle it inspects a window of RETIRE_WIDTH ROB head entries and commits the longest in-order prefix of completed entries. Register results are written through registered write ports, and stores are queued into an internal store drain buffer that issues to memory with a valid/ready handshake. A completed entry flagged with an exception stops retirement, waits for the store buffer to drain, then pulses a pipeline flush.

## Interface

- RETIRE_WIDTH, 2: ROB entries examined/committed per cycle (1..4)
- XLEN, 32: data/address width
- RADDR_W, 5: register index width
- STQ_DEPTH, 8: store drain buffer entries (power of two, >= RETIRE_WIDTH)
- clk  input  1  clock, all state on rising edge
- reset  input  1  asynchronous, active-high reset
- rob_valid  input  RETIRE_WIDTH  entry i occupied (bit 0 = ROB head)
- rob_done  input  RETIRE_WIDTH  entry i has completed execution
- rob_exc  input  RETIRE_WIDTH  entry i raised an exception
- rob_mem_write  input  RETIRE_WIDTH  entry i is a store
- rob_rd  input  RETIRE_WIDTH*RADDR_W  destination register, slot i at [i*RADDR_W +: RADDR_W]
- rob_result  input  RETIRE_WIDTH*XLEN  ALU result, or store address when store
- rob_mem_data  input  RETIRE_WIDTH*XLEN  store data
- rob_pc  input  RETIRE_WIDTH*XLEN  instruction PC
- retire_cnt  output  $clog2(RETIRE_WIDTH+1)  entries popped from ROB head this cycle (combinational)
- rf_we  output  RETIRE_WIDTH  registered write enable per port
- rf_waddr  output  RETIRE_WIDTH*RADDR_W  registered write index
- rf_wdata  output  RETIRE_WIDTH*XLEN  registered write data
- mem_valid  output  1  store buffer head valid
- mem_ready  input  1  memory accepts store
- mem_addr  output  XLEN  store buffer head address
- mem_wdata  output  XLEN  store buffer head data
- flush  output  1  one-cycle pipeline flush pulse
- exc_pc  output  XLEN  PC of faulting entry, held until next exception
- retired_total  output  32  committed-instruction counter, wraps modulo 2^32

## Operation

- States: RUN, DRAIN. Reset → RUN.
- RUN: slot i eligible iff valid & done & !exc and all slots < i eligible. Prefix length P = count of leading eligible slots.
- Store limit: stores in retired prefix must fit in free = STQ_DEPTH − count (registered count; same-cycle dequeue not credited). Prefix truncated at first store that does not fit; retire_cnt = truncated length.
- Retired non-store with rd≠0: rf_we[port]=1 next cycle, port = slot index. rd=0 and stores: rf_we=0.
- Retired stores enqueue in slot order (lowest slot first) into the FIFO.
- If first non-eligible slot j has valid & done & exc and all slots < j retire (not truncated): capture exc_pc = rob_pc[j], go DRAIN. Faulting entry is never retired.
- DRAIN: retire_cnt=0, rf_we=0. When count==0 (no dequeue pending): flush=1 for one cycle, return RUN.
- FIFO: head dequeued when mem_valid & mem_ready; mem_valid = (count≠0). Enqueue and dequeue in same cycle allowed; count updated by +enq −deq.
- retired_total += retire_cnt each cycle.

## Timing

- retire_cnt combinational from rob_* and registered state; ROB advances head at the same edge.
- rf_* valid the cycle after retire decision (1-cycle latency); rf_we deasserts automatically the following cycle.
- Store enqueued at edge of retire; earliest mem_valid the next cycle.
- mem_addr/mem_wdata stable while mem_valid & !mem_ready.
- flush asserted exactly one cycle, in the cycle after count reaches 0 in DRAIN (earliest: cycle after entering DRAIN with empty FIFO).
- Reset (any time, including mid-DRAIN): state RUN, FIFO empty, count 0, rf_we 0, mem_valid 0, flush 0, exc_pc 0, retired_total 0, rf_waddr/rf_wdata 0. Pending stores are discarded.

## Test plan

- RETIRE_WIDTH=2, both slots done non-store, rd=3/rd=7, results 0x11/0x22 → retire_cnt=2; next cycle rf_we=2'b11, waddr 3/7, data 0x11/0x22; retired_total=2.
- Slot0 not done, slot1 done → retire_cnt=0, rf_we=0 next cycle; slot0 rd=0 done → retire_cnt counts it, rf_we[0]=0.
- Two stores (addr 0x100/0x104, data 0xA/0xB), mem_ready=1 → mem_valid next cycle, 0x100/0xA then 0x104/0xB on consecutive cycles.
- mem_ready=0, STQ_DEPTH=8, stream of stores → 8 accepted, then retire_cnt=0 while store at head; raise mem_ready → one dequeue per cycle, retirement resumes when free≥1.
- Slot0 non-store done, slot1 done exc pc=0x40, one store queued, mem_ready held 0 for 3 cycles → retire_cnt=1, exc_pc=0x40, flush stays 0 until store accepted, then single-cycle flush pulse, state RUN.
- Assert reset during DRAIN with 3 queued stores → next cycle mem_valid=0, flush=0, retired_total=0, no flush pulse afterwards.

Source files
------------

// File: rtl/retire_unit.sv
// retire_unit: in-order commit stage between the ROB head and the
// architectural register file / data memory.
//
// Each cycle the RETIRE_WIDTH-entry ROB head window is scanned and the longest
// in-order prefix of completed, non-faulting entries is committed. The prefix
// is cut short when a store cannot be given a free slot in the store drain
// buffer. Register results leave through registered write ports (port i =
// slot i). Stores are queued into a FIFO that drains to memory through a
// valid/ready handshake. A completed faulting entry directly behind a fully
// committed prefix stops retirement. The unit then waits for the store buffer
// to empty and pulses flush for one cycle.
//
// Ports:
//   clk, reset         clock; asynchronous active-high reset
//   rob_*              ROB head window, slot 0 = oldest entry
//   retire_cnt         entries popped from the ROB head this cycle (comb)
//   rf_we/waddr/wdata  registered register-file write ports
//   mem_valid/ready    store drain handshake; mem_addr/mem_wdata = FIFO head
//   flush, exc_pc      one-cycle flush pulse; PC of the last faulting entry
//   retired_total      committed-instruction counter (wraps)
module retire_unit #(
  parameter int unsigned RETIRE_WIDTH = 2,
  parameter int unsigned XLEN         = 32,
  parameter int unsigned RADDR_W      = 5,
  parameter int unsigned STQ_DEPTH    = 8
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [RETIRE_WIDTH-1:0]            rob_valid,
  input  logic [RETIRE_WIDTH-1:0]            rob_done,
  input  logic [RETIRE_WIDTH-1:0]            rob_exc,
  input  logic [RETIRE_WIDTH-1:0]            rob_mem_write,
  input  logic [RETIRE_WIDTH*RADDR_W-1:0]    rob_rd,
  input  logic [RETIRE_WIDTH*XLEN-1:0]       rob_result,
  input  logic [RETIRE_WIDTH*XLEN-1:0]       rob_mem_data,
  input  logic [RETIRE_WIDTH*XLEN-1:0]       rob_pc,
  output logic [$clog2(RETIRE_WIDTH+1)-1:0]  retire_cnt,
  output logic [RETIRE_WIDTH-1:0]            rf_we,
  output logic [RETIRE_WIDTH*RADDR_W-1:0]    rf_waddr,
  output logic [RETIRE_WIDTH*XLEN-1:0]       rf_wdata,
  output logic                               mem_valid,
  input  logic                               mem_ready,
  output logic [XLEN-1:0]                    mem_addr,
  output logic [XLEN-1:0]                    mem_wdata,
  output logic                               flush,
  output logic [XLEN-1:0]                    exc_pc,
  output logic [31:0]                        retired_total
);

  localparam int unsigned CW = $clog2(RETIRE_WIDTH + 1);
  localparam int unsigned NW = $clog2(STQ_DEPTH + 1);
  // A depth-1 buffer still gets a 1-bit pointer; the count limit keeps
  // occupancy at STQ_DEPTH, so the spare storage entry is harmless.
  localparam int unsigned PW = (STQ_DEPTH > 1) ? $clog2(STQ_DEPTH) : 1;
  localparam int unsigned SN = 1 << PW;

  typedef enum logic {RUN, DRAIN} stateT;

  stateT                 state;
  logic [NW-1:0]         count;
  logic [NW-1:0]         freeSlots;
  logic [NW-1:0]         nStores;
  logic [PW-1:0]         head;
  logic [PW-1:0]         tail;
  logic [XLEN-1:0]       stqAddr [SN];
  logic [XLEN-1:0]       stqData [SN];
  logic [RETIRE_WIDTH-1:0] take;
  logic [RETIRE_WIDTH-1:0] enq;
  logic [PW-1:0]         enqPtr [RETIRE_WIDTH];
  logic                  stopScan;
  logic                  excHit;
  logic [XLEN-1:0]       excPcNext;
  logic                  deq;

  assign mem_valid = (count != '0);
  assign deq       = mem_valid & mem_ready;
  assign mem_addr  = stqAddr[head];
  assign mem_wdata = stqData[head];

  // Commit scan. freeSlots uses the registered count only: a dequeue in the
  // same cycle is not credited. A store that does not fit ends the scan, so
  // a fault behind it is not reported until the prefix reaches it.
  always_comb begin
    take       = '0;
    enq        = '0;
    nStores    = '0;
    retire_cnt = '0;
    excHit     = 1'b0;
    excPcNext  = '0;
    stopScan   = 1'b0;
    freeSlots  = NW'(STQ_DEPTH) - count;
    for (int unsigned i = 0; i < RETIRE_WIDTH; i++) begin
      enqPtr[i] = tail;
    end
    if (state == RUN) begin
      for (int unsigned i = 0; i < RETIRE_WIDTH; i++) begin
        if (!stopScan) begin
          if (rob_valid[i] & rob_done[i] & !rob_exc[i]) begin
            if (rob_mem_write[i]) begin
              if (nStores < freeSlots) begin
                take[i]   = 1'b1;
                enq[i]    = 1'b1;
                enqPtr[i] = tail + PW'(nStores);
                nStores   = nStores + NW'(1);
              end else begin
                stopScan = 1'b1;
              end
            end else begin
              take[i] = 1'b1;
            end
          end else begin
            stopScan = 1'b1;
            if (rob_valid[i] & rob_done[i]) begin
              excHit    = 1'b1;
              excPcNext = rob_pc[i*XLEN +: XLEN];
            end
          end
        end
      end
    end
    for (int unsigned i = 0; i < RETIRE_WIDTH; i++) begin
      if (take[i]) retire_cnt = retire_cnt + CW'(1);
    end
  end

  // Store buffer storage carries no reset; occupancy is tracked by count.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < RETIRE_WIDTH; i++) begin
      if (enq[i]) begin
        stqAddr[enqPtr[i]] <= rob_result[i*XLEN +: XLEN];
        stqData[enqPtr[i]] <= rob_mem_data[i*XLEN +: XLEN];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= RUN;
      count         <= '0;
      head          <= '0;
      tail          <= '0;
      rf_we         <= '0;
      rf_waddr      <= '0;
      rf_wdata      <= '0;
      flush         <= 1'b0;
      exc_pc        <= '0;
      retired_total <= '0;
    end else begin
      flush <= 1'b0;
      for (int unsigned i = 0; i < RETIRE_WIDTH; i++) begin
        rf_we[i] <= take[i] & !rob_mem_write[i] &
                    (rob_rd[i*RADDR_W +: RADDR_W] != '0);
        if (take[i] & !rob_mem_write[i] & (rob_rd[i*RADDR_W +: RADDR_W] != '0)) begin
          rf_waddr[i*RADDR_W +: RADDR_W] <= rob_rd[i*RADDR_W +: RADDR_W];
          rf_wdata[i*XLEN +: XLEN]       <= rob_result[i*XLEN +: XLEN];
        end
      end
      head          <= head + PW'(deq);
      tail          <= tail + PW'(nStores);
      count         <= count + nStores - NW'(deq);
      retired_total <= retired_total + 32'(retire_cnt);
      case (state)
        RUN: begin
          if (excHit) begin
            state  <= DRAIN;
            exc_pc <= excPcNext;
          end
        end
        DRAIN: begin
          if (count == '0) begin
            flush <= 1'b1;
            state <= RUN;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule
